mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_id_fifo.sv | 57 +++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-to-memory arbiter: client identifiers and defaults.
package mem_arb_pkg;

    typedef enum logic {
        CL_IC = 1'b0,
        CL_DC = 1'b1
    } client_t;

    localparam int OUTSTANDING_DEFAULT = 4;

    function automatic client_t other_client(input client_t c);
        return (c == CL_IC) ? CL_DC : CL_IC;
    endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Owner-ID FIFO: remembers which client issued each in-flight read, in issue order.
module mem_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEFAULT,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          push,
    input  client_t       push_id,
    input  logic          pop,
    output client_t       head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    client_t       slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot contents need no reset: they are only read when count says they are live.
    always_ff @(posedge i_clk) begin
        if (do_push) slots[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin merge of icache and dcache word interfaces onto one memory port,
// with in-order read response routing back to the issuing cache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEFAULT,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ic_ren,
    input  logic [AW-1:0] i_ic_addr,
    output logic          o_ic_ready,
    output logic [DW-1:0] o_ic_rdata,
    output logic          o_ic_valid,
    input  logic          i_dc_ren,
    input  logic          i_dc_wen,
    input  logic [AW-1:0] i_dc_addr,
    input  logic [DW-1:0] i_dc_wdata,
    output logic          o_dc_ready,
    output logic [DW-1:0] o_dc_rdata,
    output logic          o_dc_valid,
    input  logic          i_mem_ready,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_ren,
    output logic          o_mem_wen,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_valid,
    output logic          o_err
);

    localparam int CW = $clog2(OUTSTANDING + 1);

    client_t       last_grant;
    client_t       fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic read_ok;
    logic dc_write;
    logic ic_elig;
    logic dc_elig;
    logic gnt_ic;
    logic gnt_dc;
    logic accept;
    logic push_read;
    logic pop_resp;

    // A dcache request with both ren and wen is handled as a write.
    assign dc_write = i_dc_wen;
    assign read_ok  = (fifo_count < CW'(OUTSTANDING));
    assign ic_elig  = i_ic_ren & read_ok;
    assign dc_elig  = dc_write | (i_dc_ren & read_ok);

    always_comb begin
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        if (ic_elig && dc_elig) begin
            if (other_client(last_grant) == CL_DC) gnt_dc = 1'b1;
            else                                   gnt_ic = 1'b1;
        end else if (ic_elig) begin
            gnt_ic = 1'b1;
        end else if (dc_elig) begin
            gnt_dc = 1'b1;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        if (gnt_dc) begin
            o_mem_addr = i_dc_addr;
            if (dc_write) begin
                o_mem_wen   = i_rst_n;
                o_mem_wdata = i_dc_wdata;
            end else begin
                o_mem_ren = i_rst_n;
            end
        end else if (gnt_ic) begin
            o_mem_addr = i_ic_addr;
            o_mem_ren  = i_rst_n;
        end
    end

    assign o_ic_ready = gnt_ic & i_mem_ready & i_rst_n;
    assign o_dc_ready = gnt_dc & i_mem_ready & i_rst_n;
    assign accept     = o_ic_ready | o_dc_ready;
    assign push_read  = o_ic_ready | (o_dc_ready & ~dc_write);

    // Responses come back in issue order, so the FIFO head names the owner.
    assign pop_resp   = i_mem_valid & ~fifo_empty & i_rst_n;
    assign o_ic_valid = pop_resp & (fifo_head == CL_IC);
    assign o_dc_valid = pop_resp & (fifo_head == CL_DC);
    assign o_ic_rdata = i_mem_rdata;
    assign o_dc_rdata = i_mem_rdata;

    mem_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push_read & read_ok),
        .push_id (gnt_dc ? CL_DC : CL_IC),
        .pop     (pop_resp),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant <= CL_IC;
            o_err      <= 1'b0;
        end else begin
            if (accept) last_grant <= gnt_dc ? CL_DC : CL_IC;
            if ((i_mem_valid && fifo_empty) || (i_dc_ren && i_dc_wen) ||
                (push_read && fifo_full))
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, response routing, full FIFO, stalls, errors, reset.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ic_ren;
    logic [31:0] i_ic_addr;
    logic        o_ic_ready;
    logic [31:0] o_ic_rdata;
    logic        o_ic_valid;
    logic        i_dc_ren;
    logic        i_dc_wen;
    logic [31:0] i_dc_addr;
    logic [31:0] i_dc_wdata;
    logic        o_dc_ready;
    logic [31:0] o_dc_rdata;
    logic        o_dc_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.OUTSTANDING(4), .AW(32), .DW(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ic_ren(i_ic_ren), .i_ic_addr(i_ic_addr), .o_ic_ready(o_ic_ready),
        .o_ic_rdata(o_ic_rdata), .o_ic_valid(o_ic_valid),
        .i_dc_ren(i_dc_ren), .i_dc_wen(i_dc_wen), .i_dc_addr(i_dc_addr),
        .i_dc_wdata(i_dc_wdata), .o_dc_ready(o_dc_ready), .o_dc_rdata(o_dc_rdata),
        .o_dc_valid(o_dc_valid),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .i_mem_valid(i_mem_valid), .o_err(o_err)
    );

    task automatic clear_inputs();
        i_ic_ren = 0; i_ic_addr = '0; i_dc_ren = 0; i_dc_wen = 0;
        i_dc_addr = '0; i_dc_wdata = '0; i_mem_ready = 1; i_mem_rdata = '0; i_mem_valid = 0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst_n = 0;
        next_cycle();
        i_rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst_n = 0;
        i_ic_ren = 1; i_dc_ren = 1; i_mem_valid = 1;
        #3;
        checks++;
        if ({o_ic_ready, o_dc_ready, o_mem_ren, o_mem_wen, o_ic_valid, o_dc_valid, o_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {o_ic_ready, o_dc_ready, o_mem_ren, o_mem_wen, o_ic_valid, o_dc_valid, o_err});
        end
        do_reset();
        checks++;
        if ({o_ic_ready, o_dc_ready, o_mem_ren, o_mem_wen, o_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b required 00000",
                     {o_ic_ready, o_dc_ready, o_mem_ren, o_mem_wen, o_err});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        i_ic_ren = 1; i_ic_addr = 32'h100;
        #1;
        checks++;
        if (o_ic_ready !== 1'b1 || o_mem_ren !== 1'b1 || o_mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL single_issue: ready=%b ren=%b addr=%h required 1 1 00000100",
                     o_ic_ready, o_mem_ren, o_mem_addr);
        end
        next_cycle();
        i_ic_ren = 0;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++;
            if (o_ic_valid !== 1'b0 || o_dc_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_wait%0d: ic_valid=%b dc_valid=%b required 0 0", c, o_ic_valid, o_dc_valid);
            end
            next_cycle();
        end
        i_mem_valid = 1; i_mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (o_ic_valid !== 1'b1 || o_ic_rdata !== 32'hDEADBEEF || o_dc_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: ic_valid=%b rdata=%h dc_valid=%b required 1 deadbeef 0",
                     o_ic_valid, o_ic_rdata, o_dc_valid);
        end
        next_cycle();
        i_mem_valid = 0;
        #1;
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL single_err: got %b required 0", o_err);
        end
    endtask

    task automatic test_round_robin();
        logic exp_dc [4];
        logic [31:0] resp [4];
        exp_dc = '{1'b1, 1'b0, 1'b1, 1'b0};
        resp = '{32'hA, 32'hB, 32'hC, 32'hD};
        do_reset();
        i_ic_ren = 1; i_ic_addr = 32'h200;
        i_dc_ren = 1; i_dc_addr = 32'h300;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (o_dc_ready !== exp_dc[c] || o_ic_ready !== ~exp_dc[c] ||
                o_mem_addr !== (exp_dc[c] ? 32'h300 : 32'h200)) begin
                errors++;
                $display("FAIL rr_grant%0d: dc_ready=%b ic_ready=%b addr=%h required dc_ready=%b",
                         c, o_dc_ready, o_ic_ready, o_mem_addr, exp_dc[c]);
            end
            next_cycle();
        end
        i_ic_ren = 0; i_dc_ren = 0;
        for (int c = 0; c < 4; c++) begin
            i_mem_valid = 1; i_mem_rdata = resp[c];
            #1;
            checks++;
            if (o_dc_valid !== exp_dc[c] || o_ic_valid !== ~exp_dc[c] ||
                (exp_dc[c] ? o_dc_rdata : o_ic_rdata) !== resp[c]) begin
                errors++;
                $display("FAIL rr_resp%0d: dc_valid=%b ic_valid=%b required dc_valid=%b data %h",
                         c, o_dc_valid, o_ic_valid, exp_dc[c], resp[c]);
            end
            next_cycle();
        end
        i_mem_valid = 0;
        #1;
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL rr_err: got %b required 0", o_err);
        end
    endtask

    task automatic test_full_fifo();
        do_reset();
        i_dc_ren = 1; i_dc_addr = 32'h400;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (o_dc_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d: dc_ready=%b required 1", c, o_dc_ready);
            end
            next_cycle();
        end
        #1;
        checks++;
        if (o_dc_ready !== 1'b0 || o_mem_ren !== 1'b0) begin
            errors++;
            $display("FAIL full_block: dc_ready=%b mem_ren=%b required 0 0", o_dc_ready, o_mem_ren);
        end
        i_dc_ren = 0; i_dc_wen = 1; i_dc_wdata = 32'hCAFE0001; i_dc_addr = 32'h500;
        i_ic_ren = 1; i_ic_addr = 32'h600;
        #1;
        checks++;
        if (o_dc_ready !== 1'b1 || o_ic_ready !== 1'b0 || o_mem_wen !== 1'b1 ||
            o_mem_ren !== 1'b0 || o_mem_wdata !== 32'hCAFE0001 || o_mem_addr !== 32'h500) begin
            errors++;
            $display("FAIL full_write: dc_ready=%b ic_ready=%b wen=%b ren=%b wdata=%h addr=%h required 1 0 1 0 cafe0001 00000500",
                     o_dc_ready, o_ic_ready, o_mem_wen, o_mem_ren, o_mem_wdata, o_mem_addr);
        end
        next_cycle();
        i_dc_wen = 0; i_ic_ren = 0; i_dc_ren = 1; i_dc_addr = 32'h700;
        i_mem_valid = 1; i_mem_rdata = 32'h11;
        #1;
        checks++;
        if (o_dc_valid !== 1'b1 || o_dc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: dc_valid=%b dc_ready=%b required 1 0", o_dc_valid, o_dc_ready);
        end
        next_cycle();
        i_mem_valid = 0;
        #1;
        checks++;
        if (o_dc_ready !== 1'b1 || o_mem_addr !== 32'h700) begin
            errors++;
            $display("FAIL full_reaccept: dc_ready=%b addr=%h required 1 00000700", o_dc_ready, o_mem_addr);
        end
        next_cycle();
        i_dc_ren = 0;
    endtask

    task automatic test_stall();
        do_reset();
        i_mem_ready = 0; i_ic_ren = 1; i_ic_addr = 32'h800;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (o_ic_ready !== 1'b0 || o_mem_ren !== 1'b1 || o_mem_addr !== 32'h800) begin
                errors++;
                $display("FAIL stall%0d: ready=%b ren=%b addr=%h required 0 1 00000800",
                         c, o_ic_ready, o_mem_ren, o_mem_addr);
            end
            next_cycle();
        end
        i_mem_ready = 1;
        #1;
        checks++;
        if (o_ic_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ready=%b required 1", o_ic_ready);
        end
        next_cycle();
        i_ic_ren = 0;
    endtask

    task automatic test_errors();
        do_reset();
        i_mem_valid = 1; i_mem_rdata = 32'h55;
        #1;
        checks++;
        if (o_ic_valid !== 1'b0 || o_dc_valid !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_same: ic_valid=%b dc_valid=%b err=%b required 0 0 0", o_ic_valid, o_dc_valid, o_err);
        end
        next_cycle();
        i_mem_valid = 0;
        #1;
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_err: got %b required 1", o_err);
        end
        do_reset();
        i_dc_ren = 1; i_dc_wen = 1; i_dc_wdata = 32'h77; i_dc_addr = 32'h900;
        #1;
        checks++;
        if (o_mem_wen !== 1'b1 || o_mem_ren !== 1'b0 || o_mem_wdata !== 32'h77) begin
            errors++;
            $display("FAIL both_wen: wen=%b ren=%b wdata=%h required 1 0 00000077", o_mem_wen, o_mem_ren, o_mem_wdata);
        end
        next_cycle();
        i_dc_ren = 0; i_dc_wen = 0;
        #1;
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL both_err: got %b required 1", o_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        i_ic_ren = 1; i_ic_addr = 32'hA00;
        next_cycle();
        next_cycle();
        i_rst_n = 0; i_mem_valid = 1; i_dc_wen = 1;
        #2;
        checks++;
        if ({o_ic_ready, o_dc_ready, o_mem_ren, o_mem_wen, o_ic_valid, o_dc_valid, o_err} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 0000000",
                     {o_ic_ready, o_dc_ready, o_mem_ren, o_mem_wen, o_ic_valid, o_dc_valid, o_err});
        end
        clear_inputs();
        next_cycle();
        i_rst_n = 1;
        #1;
        i_mem_valid = 1; i_mem_rdata = 32'h99;
        #1;
        checks++;
        if (o_ic_valid !== 1'b0 || o_dc_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stray_valid: ic_valid=%b dc_valid=%b required 0 0", o_ic_valid, o_dc_valid);
        end
        next_cycle();
        i_mem_valid = 0;
        #1;
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_stray_err: got %b required 1", o_err);
        end
    endtask

    initial begin
        clear_inputs();
        i_rst_n = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_full_fifo();
        test_stall();
        test_errors();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
